dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between the pipeline MEM stage (core) and an external loader/debug requester (ext).
- Sits between the EX/MEM register outputs and the datamemory instance.
- The core has priority by default. A wait counter bounds how long ext can starve.
- When ext wins a cycle, the block raises a stall so the core holds its MEM-stage access.

---
 rtl/dmem_port_arbiter_pkg.sv | 35 +++
 rtl/dmem_port_arbiter_if.sv | 50 +++++
 rtl/dmem_port_arbiter.sv | 102 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - shared types for the data-memory port arbiter
package dmem_port_arbiter_pkg;

   localparam int DMEM_DATA_W       = 32;
   localparam int DMEM_ADDR_W       = 9;
   localparam int DMEM_MAX_EXT_WAIT = 4;

   typedef struct packed {
      logic                   rd;
      logic                   wr;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
      logic [2:0]             funct3;
   } dmem_req_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_CORE,
      GNT_EXT
   } grant_t;

   // ext wins whenever the core is idle, or when its wait has been forced.
   function automatic grant_t grant_f(input logic core_req, input logic ext_valid,
                                      input logic ext_forced);
      grant_t g;
      g = GNT_NONE;
      if (ext_valid && (!core_req || ext_forced)) begin
         g = GNT_EXT;
      end else if (core_req) begin
         g = GNT_CORE;
      end
      return g;
   endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - core, ext and data-memory signals around the arbiter
interface dmem_arb_if
   import dmem_port_arbiter_pkg::*;
#(
   parameter int DATA_W     = DMEM_DATA_W,
   parameter int DM_ADDRESS = DMEM_ADDR_W
);
   logic                  core_rd;
   logic                  core_wr;
   logic [DM_ADDRESS-1:0] core_addr;
   logic [DATA_W-1:0]     core_wdata;
   logic [2:0]            core_funct3;
   logic [DATA_W-1:0]     core_rdata;
   logic                  core_stall;

   logic                  ext_valid;
   logic                  ext_we;
   logic [DM_ADDRESS-1:0] ext_addr;
   logic [DATA_W-1:0]     ext_wdata;
   logic [2:0]            ext_funct3;
   logic                  ext_ready;
   logic                  ext_rvalid;
   logic [DATA_W-1:0]     ext_rdata;

   logic                  mem_rd;
   logic                  mem_wr;
   logic [DM_ADDRESS-1:0] mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [2:0]            mem_funct3;
   logic [DATA_W-1:0]     mem_rdata;

   modport slave (
      input  core_rd, core_wr, core_addr, core_wdata, core_funct3,
      output core_rdata, core_stall,
      input  ext_valid, ext_we, ext_addr, ext_wdata, ext_funct3,
      output ext_ready, ext_rvalid, ext_rdata,
      output mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
      input  mem_rdata
   );

   modport master (
      output core_rd, core_wr, core_addr, core_wdata, core_funct3,
      input  core_rdata, core_stall,
      output ext_valid, ext_we, ext_addr, ext_wdata, ext_funct3,
      input  ext_ready, ext_rvalid, ext_rdata,
      input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the data-memory port between the MEM stage and an ext requester
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int DATA_W       = DMEM_DATA_W,
   parameter int DM_ADDRESS   = DMEM_ADDR_W,
   parameter int MAX_EXT_WAIT = DMEM_MAX_EXT_WAIT
) (
   input logic        clk_i,
   input logic        reset_ni,
   dmem_arb_if.slave  bus
);

   localparam int CNT_W = $clog2(MAX_EXT_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_EXT_WAIT);

   dmem_req_t             core_req_s;
   dmem_req_t             ext_req_s;
   dmem_req_t             mem_req_s;
   grant_t                grant;
   logic                  core_req;
   logic                  ext_forced;
   logic                  ext_gnt;
   logic [DM_ADDRESS-1:0] mem_addr_s;

   logic [CNT_W-1:0]      wait_cnt_q,  wait_cnt_d;
   logic                  last_ext_q,  last_ext_d;
   logic                  rvalid_q,    rvalid_d;
   logic [DATA_W-1:0]     rdata_q,     rdata_d;

   // A core asserting both rd and wr is treated as a write.
   always_comb begin
      core_req_s = '{rd:     bus.core_rd & ~bus.core_wr,
                     wr:     bus.core_wr,
                     addr:   bus.core_addr,
                     wdata:  bus.core_wdata,
                     funct3: bus.core_funct3};
      ext_req_s  = '{rd:     ~bus.ext_we,
                     wr:     bus.ext_we,
                     addr:   bus.ext_addr,
                     wdata:  bus.ext_wdata,
                     funct3: bus.ext_funct3};
   end

   assign core_req   = bus.core_rd | bus.core_wr;
   assign ext_forced = (wait_cnt_q == WAIT_MAX) && !last_ext_q;
   assign grant      = grant_f(core_req, bus.ext_valid, ext_forced);
   assign ext_gnt    = (grant == GNT_EXT);

   always_comb begin
      mem_req_s = '0;
      case (grant)
         GNT_CORE: mem_req_s = core_req_s;
         GNT_EXT:  mem_req_s = ext_req_s;
         default:  mem_req_s = '0;
      endcase
   end

   assign mem_addr_s     = mem_req_s.addr;
   assign bus.mem_rd     = mem_req_s.rd;
   assign bus.mem_wr     = mem_req_s.wr;
   assign bus.mem_addr   = mem_addr_s;
   assign bus.mem_wdata  = mem_req_s.wdata;
   assign bus.mem_funct3 = mem_req_s.funct3;

   assign bus.core_rdata = bus.mem_rdata;
   assign bus.core_stall = core_req & ext_gnt;
   assign bus.ext_ready  = ext_gnt;
   assign bus.ext_rvalid = rvalid_q;
   assign bus.ext_rdata  = rdata_q;

   // Starvation counter: only counts while ext is actually being refused.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      last_ext_d = ext_gnt;
      rvalid_d   = ext_gnt & ~bus.ext_we;
      rdata_d    = rdata_q;
      if (!bus.ext_valid || ext_gnt) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != WAIT_MAX) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
      if (rvalid_d) begin
         rdata_d = bus.mem_rdata;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wait_cnt_q <= '0;
         last_ext_q <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         last_ext_q <= last_ext_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
   import dmem_port_arbiter_pkg::*;

   logic clk;
   logic reset_n;
   int   checks;
   int   failures;

   dmem_arb_if bus ();

   dmem_port_arbiter #(
      .DATA_W       (32),
      .DM_ADDRESS   (9),
      .MAX_EXT_WAIT (4)
   ) dut (
      .clk_i    (clk),
      .reset_ni (reset_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven there and
   // outputs are sampled 1ns later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.core_rd     = 1'b0;
      bus.core_wr     = 1'b0;
      bus.core_addr   = '0;
      bus.core_wdata  = '0;
      bus.core_funct3 = 3'd2;
      bus.ext_valid   = 1'b0;
      bus.ext_we      = 1'b0;
      bus.ext_addr    = '0;
      bus.ext_wdata   = '0;
      bus.ext_funct3  = 3'd2;
      bus.mem_rdata   = '0;
   endtask

   int consec_stall;
   int max_consec_stall;

   initial begin
      checks   = 0;
      failures = 0;
      idle_inputs();
      reset_n = 1'b0;
      #12;
      check_eq("reset_rvalid", {31'd0, bus.ext_rvalid}, 32'd0);
      check_eq("reset_rdata", bus.ext_rdata, 32'd0);
      check_eq("idle_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
      check_eq("idle_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      check_eq("idle_mem_addr", {23'd0, bus.mem_addr}, 32'd0);
      reset_n = 1'b1;

      // Core-only read
      next_cycle();
      bus.core_rd   = 1'b1;
      bus.core_addr = 9'h010;
      bus.mem_rdata = 32'hDEADBEEF;
      #1;
      check_eq("core_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
      check_eq("core_mem_addr", {23'd0, bus.mem_addr}, 32'h010);
      check_eq("core_rdata", bus.core_rdata, 32'hDEADBEEF);
      check_eq("core_stall", {31'd0, bus.core_stall}, 32'd0);
      check_eq("core_ext_ready", {31'd0, bus.ext_ready}, 32'd0);

      // Ext-only read with one-cycle return
      next_cycle();
      idle_inputs();
      bus.ext_valid = 1'b1;
      bus.ext_addr  = 9'h020;
      bus.mem_rdata = 32'h12345678;
      #1;
      check_eq("ext_ready_T", {31'd0, bus.ext_ready}, 32'd1);
      check_eq("ext_mem_rd_T", {31'd0, bus.mem_rd}, 32'd1);
      check_eq("ext_mem_addr_T", {23'd0, bus.mem_addr}, 32'h020);
      check_eq("ext_rvalid_T", {31'd0, bus.ext_rvalid}, 32'd0);
      next_cycle();
      bus.ext_valid = 1'b0;
      bus.mem_rdata = 32'hCAFEF00D;
      #1;
      check_eq("ext_rvalid_T1", {31'd0, bus.ext_rvalid}, 32'd1);
      check_eq("ext_rdata_T1", bus.ext_rdata, 32'h12345678);
      next_cycle();
      check_eq("ext_rvalid_T2", {31'd0, bus.ext_rvalid}, 32'd0);
      check_eq("ext_rdata_hold", bus.ext_rdata, 32'h12345678);

      // Continuous core reads with a pending ext write: forced grant on cycle 5
      bus.core_rd    = 1'b1;
      bus.core_addr  = 9'h044;
      bus.ext_valid  = 1'b1;
      bus.ext_we     = 1'b1;
      bus.ext_addr   = 9'h033;
      bus.ext_wdata  = 32'h0000A5A5;
      for (int c = 1; c <= 6; c++) begin
         if (c == 6) bus.ext_valid = 1'b0;
         #1;
         check_eq($sformatf("starve_ready_c%0d", c), {31'd0, bus.ext_ready}, {31'd0, c == 5});
         check_eq($sformatf("starve_stall_c%0d", c), {31'd0, bus.core_stall}, {31'd0, c == 5});
         check_eq($sformatf("starve_mem_wr_c%0d", c), {31'd0, bus.mem_wr}, {31'd0, c == 5});
         check_eq($sformatf("starve_mem_rd_c%0d", c), {31'd0, bus.mem_rd}, {31'd0, c != 5});
         check_eq($sformatf("starve_addr_c%0d", c), {23'd0, bus.mem_addr},
                  (c == 5) ? 32'h033 : 32'h044);
         if (c == 5) check_eq("starve_wdata", bus.mem_wdata, 32'h0000A5A5);
         next_cycle();
      end
      check_eq("write_no_rvalid", {31'd0, bus.ext_rvalid}, 32'd0);

      // Back-to-back ext requests under continuous core traffic
      bus.ext_valid    = 1'b1;
      consec_stall     = 0;
      max_consec_stall = 0;
      for (int c = 1; c <= 12; c++) begin
         #1;
         check_eq($sformatf("b2b_ready_c%0d", c), {31'd0, bus.ext_ready}, {31'd0, (c % 5) == 0});
         consec_stall = bus.core_stall ? consec_stall + 1 : 0;
         if (consec_stall > max_consec_stall) max_consec_stall = consec_stall;
         next_cycle();
      end
      check_eq("b2b_max_consec_stall", max_consec_stall, 32'd1);

      // Abort after 2 denied cycles, then reassert: counter restarts
      bus.ext_valid = 1'b0;
      next_cycle();
      bus.ext_valid = 1'b1;
      for (int c = 1; c <= 2; c++) begin
         #1;
         check_eq($sformatf("abort_pre_c%0d", c), {31'd0, bus.ext_ready}, 32'd0);
         next_cycle();
      end
      bus.ext_valid = 1'b0;
      next_cycle();
      bus.ext_valid = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         #1;
         check_eq($sformatf("abort_re_c%0d", c), {31'd0, bus.ext_ready}, {31'd0, c == 5});
         next_cycle();
      end

      // Reset between an accepted read and its response
      idle_inputs();
      bus.ext_valid = 1'b1;
      bus.ext_addr  = 9'h055;
      bus.mem_rdata = 32'h55AA55AA;
      #1;
      check_eq("rst_read_ready", {31'd0, bus.ext_ready}, 32'd1);
      next_cycle();
      bus.core_rd   = 1'b1;
      bus.ext_valid = 1'b1;
      reset_n       = 1'b0;
      #1;
      check_eq("rst_rvalid_now", {31'd0, bus.ext_rvalid}, 32'd0);
      check_eq("rst_rdata_now", bus.ext_rdata, 32'd0);
      check_eq("rst_core_stall", {31'd0, bus.core_stall}, 32'd0);
      check_eq("rst_ext_ready", {31'd0, bus.ext_ready}, 32'd0);
      next_cycle();
      bus.core_rd   = 1'b0;
      bus.ext_valid = 1'b0;
      reset_n       = 1'b1;
      next_cycle();
      check_eq("rst_rvalid_after", {31'd0, bus.ext_rvalid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
